fe_inv_seq: RTL and testbench

- Sequential modular inverter/divider over the bn128 base field. Returns o_dat = b * a^-1 mod P using the binary extended Euclidean algorithm, one algorithm step per clock.
- Sits directly downstream of the Jacobian point-multiply / multiexp datapath. It supplies z^-1 for Jacobian-to-affine conversion; the numerator input also lets callers compute x/z^2 directly.
- Streaming valid/ready handshake on both sides; one operation in flight.

---
 rtl/bn128_pkg.sv | 85 ++++++++
 rtl/fe_inv_step.sv | 59 +++++
 rtl/fe_inv_seq.sv | 148 ++++++++++++++
 tb/tb_fe_inv_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bn128_pkg.sv
// ---------------------------------------------------------------------------
// bn128_pkg
// Shared definitions for the bn128 base-field datapath.
//   DAT_BITS  : field element width
//   MAX_ITER  : step ceiling for the sequential inverter
//   P         : bn128 base-field modulus
//   fe_t      : field element type
// Helper functions: fe_add, fe_sub, fe_half (used by the datapath), and
// fe_mul, fe_pow, fe_inv (straightforward reference arithmetic for models).
// ---------------------------------------------------------------------------
package bn128_pkg;

  localparam int DAT_BITS  = 256;
  localparam int MAX_ITER  = 1100;
  localparam int ITER_BITS = $clog2(MAX_ITER);

  typedef logic [DAT_BITS-1:0] fe_t;

  localparam fe_t P = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } inv_state_t;

  // (x + y) mod P for x, y in [0, P)
  function automatic fe_t fe_add(input fe_t x, input fe_t y);
    logic [DAT_BITS:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, P})
      s = s - {1'b0, P};
    return fe_t'(s);
  endfunction

  // (x - y) mod P for x, y in [0, P); the wrap adds P before subtracting so
  // the intermediate never goes negative in DAT_BITS+1 bits
  function automatic fe_t fe_sub(input fe_t x, input fe_t y);
    logic [DAT_BITS:0] d;
    if (y > x)
      d = {1'b0, x} + {1'b0, P} - {1'b0, y};
    else
      d = {1'b0, x} - {1'b0, y};
    return fe_t'(d);
  endfunction

  // x / 2 mod P: an odd x becomes even once P (odd) is added
  function automatic fe_t fe_half(input fe_t x);
    logic [DAT_BITS:0] s;
    s = {1'b0, x} + (x[0] ? {1'b0, P} : {(DAT_BITS+1){1'b0}});
    return fe_t'(s >> 1);
  endfunction

  // x * y mod P, MSB-first double-and-add
  function automatic fe_t fe_mul(input fe_t x, input fe_t y);
    fe_t r;
    r = '0;
    for (int i = DAT_BITS - 1; i >= 0; i--) begin
      r = fe_add(r, r);
      if (y[i])
        r = fe_add(r, x);
    end
    return r;
  endfunction

  // base ^ e mod P, square-and-multiply
  function automatic fe_t fe_pow(input fe_t base, input fe_t e);
    fe_t r;
    r = fe_t'(1);
    for (int i = DAT_BITS - 1; i >= 0; i--) begin
      r = fe_mul(r, r);
      if (e[i])
        r = fe_mul(r, base);
    end
    return r;
  endfunction

  // b / a mod P via Fermat (a^(P-2)); a == 0 yields 0
  function automatic fe_t fe_inv(input fe_t a, input fe_t b);
    if (a == '0)
      return '0;
    return fe_mul(fe_pow(a, P - fe_t'(2)), b);
  endfunction

endpackage

// File: rtl/fe_inv_step.sv
// ---------------------------------------------------------------------------
// fe_inv_step
// One combinational step of the binary extended Euclidean algorithm.
//   u, v, x1, x2          : current algorithm registers
//   u_nxt, v_nxt,
//   x1_nxt, x2_nxt        : register values after this step
//   done                  : u == 1 or v == 1, result is available on res
//   res                   : x1 when u == 1, otherwise x2
// When done is set the next-state outputs simply echo the inputs.
// ---------------------------------------------------------------------------
module fe_inv_step
  import bn128_pkg::*;
(
  input  logic [DAT_BITS-1:0] u,
  input  logic [DAT_BITS-1:0] v,
  input  logic [DAT_BITS-1:0] x1,
  input  logic [DAT_BITS-1:0] x2,
  output logic [DAT_BITS-1:0] u_nxt,
  output logic [DAT_BITS-1:0] v_nxt,
  output logic [DAT_BITS-1:0] x1_nxt,
  output logic [DAT_BITS-1:0] x2_nxt,
  output logic                done,
  output logic [DAT_BITS-1:0] res
);

  logic u_one;
  logic v_one;

  assign u_one = (u == fe_t'(1));
  assign v_one = (v == fe_t'(1));
  assign done  = u_one | v_one;
  assign res   = u_one ? x1 : x2;

  // Priority chain: strip factors of two from u first, then v, then reduce
  // the larger of the two by the smaller. Invariants x1*a == u*b and
  // x2*a == v*b (mod P) hold throughout.
  always_comb begin
    u_nxt  = u;
    v_nxt  = v;
    x1_nxt = x1;
    x2_nxt = x2;
    if (u_one || v_one) begin
      u_nxt = u;
    end else if (!u[0]) begin
      u_nxt  = u >> 1;
      x1_nxt = fe_half(x1);
    end else if (!v[0]) begin
      v_nxt  = v >> 1;
      x2_nxt = fe_half(x2);
    end else if (u >= v) begin
      u_nxt  = u - v;
      x1_nxt = fe_sub(x1, x2);
    end else begin
      v_nxt  = v - u;
      x2_nxt = fe_sub(x2, x1);
    end
  end

endmodule

// File: rtl/fe_inv_seq.sv
// ---------------------------------------------------------------------------
// fe_inv_seq
// Sequential modular divider over the bn128 base field: o_dat = b / a mod P,
// one binary-EEA step per clock, one operation in flight.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_a, i_b       : denominator / numerator (both < P), i_b = 1 for inverse
//   i_val, o_rdy   : input handshake
//   o_dat, o_err   : result; o_err flags a == 0 or step ceiling reached
//   o_val, i_rdy   : output handshake
// ---------------------------------------------------------------------------
module fe_inv_seq
  import bn128_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [DAT_BITS-1:0] i_a,
  input  logic [DAT_BITS-1:0] i_b,
  input  logic                i_val,
  output logic                o_rdy,
  output logic [DAT_BITS-1:0] o_dat,
  output logic                o_err,
  output logic                o_val,
  input  logic                i_rdy
);

  inv_state_t           state_q, state_d;
  fe_t                  u_q, v_q, x1_q, x2_q;
  fe_t                  u_d, v_d, x1_d, x2_d;
  logic [ITER_BITS-1:0] iter_q, iter_d;
  fe_t                  dat_q, dat_d;
  logic                 err_q, err_d;
  logic                 val_q, val_d;
  logic                 rdy_q, rdy_d;

  fe_t  step_u, step_v, step_x1, step_x2, step_res;
  logic step_done;
  logic accept;

  fe_inv_step u_step (
    .u      (u_q),
    .v      (v_q),
    .x1     (x1_q),
    .x2     (x2_q),
    .u_nxt  (step_u),
    .v_nxt  (step_v),
    .x1_nxt (step_x1),
    .x2_nxt (step_x2),
    .done   (step_done),
    .res    (step_res)
  );

  assign accept = i_val && rdy_q;

  // Next-state and output logic. o_rdy is registered from the next state so
  // that it reads 0 during reset and rises one clock after release.
  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    iter_d  = iter_q;
    dat_d   = dat_q;
    err_d   = err_q;
    val_d   = val_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          u_d    = i_a;
          v_d    = P;
          x1_d   = i_b;
          x2_d   = '0;
          iter_d = '0;
          if (i_a == '0) begin
            dat_d   = '0;
            err_d   = 1'b1;
            val_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        iter_d = iter_q + ITER_BITS'(1);
        if (step_done) begin
          dat_d   = step_res;
          val_d   = 1'b1;
          state_d = DONE;
        end else if (iter_q == ITER_BITS'(MAX_ITER - 1)) begin
          dat_d   = '0;
          err_d   = 1'b1;
          val_d   = 1'b1;
          state_d = DONE;
        end else begin
          u_d  = step_u;
          v_d  = step_v;
          x1_d = step_x1;
          x2_d = step_x2;
        end
      end
      DONE: begin
        if (i_rdy) begin
          val_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rdy_d = (state_d == IDLE);
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      iter_q  <= '0;
      dat_q   <= '0;
      err_q   <= 1'b0;
      val_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      iter_q  <= iter_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
      val_q   <= val_d;
      rdy_q   <= rdy_d;
    end
  end

  assign o_rdy = rdy_q;
  assign o_dat = dat_q;
  assign o_err = err_q;
  assign o_val = val_q;

endmodule

// File: tb/tb_fe_inv_seq.sv
// ---------------------------------------------------------------------------
// tb_fe_inv_seq
// Self-checking bench for fe_inv_seq. Expected quotients come from Fermat
// exponentiation (fe_inv) and are cross-checked by multiplying back.
// ---------------------------------------------------------------------------
module tb_fe_inv_seq;
  import bn128_pkg::*;

  localparam int N_RAND = 80;
  localparam int LAT_MAX = MAX_ITER + 2;

  logic clk;
  logic rst_n;
  fe_t  i_a;
  fe_t  i_b;
  logic i_val;
  logic o_rdy;
  fe_t  o_dat;
  logic o_err;
  logic o_val;
  logic i_rdy;

  int checks;
  int errors;

  fe_inv_seq dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_val   (i_val),
    .o_rdy   (o_rdy),
    .o_dat   (o_dat),
    .o_err   (o_err),
    .o_val   (o_val),
    .i_rdy   (i_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fe_t rand_fe();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string tag, input fe_t obs, input fe_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Run one operation. exp_lat == 0 means only the latency bound is checked.
  // With noisy set, junk i_val/i_a/i_b is driven while busy and the result
  // is stalled with random backpressure.
  task automatic applyStimulus(input fe_t a, input fe_t b,
                               input fe_t exp_dat, input logic exp_err,
                               input int exp_lat, input bit noisy);
    int guard;
    int lat;
    int stall;
    guard = 0;
    while (!o_rdy && guard < LAT_MAX) begin
      @(posedge clk); #1;
      guard++;
    end
    checkBit("rdy_before_accept", o_rdy, 1'b1);
    i_a   = a;
    i_b   = b;
    i_val = 1'b1;
    @(posedge clk); #1;
    i_val = 1'b0;
    checkBit("rdy_low_busy", o_rdy, 1'b0);
    lat = 1;
    while (!o_val && lat < LAT_MAX) begin
      if (noisy) begin
        i_val = 1'($urandom_range(0, 1));
        i_a   = rand_fe();
        i_b   = rand_fe();
      end
      @(posedge clk); #1;
      lat++;
    end
    i_val = 1'b0;
    checkBit("val_rise", o_val, 1'b1);
    checkBit("lat_bound", (lat <= LAT_MAX), 1'b1);
    if (exp_lat != 0)
      checkOutput("latency", fe_t'(lat), fe_t'(exp_lat));
    checkOutput("dat", o_dat, exp_dat);
    checkBit("err", o_err, exp_err);
    if (!exp_err)
      checkOutput("mul_back", fe_mul(o_dat, a), b);
    stall = noisy ? $urandom_range(0, 3) : 0;
    for (int k = 0; k < stall; k++) begin
      i_rdy = 1'b0;
      @(posedge clk); #1;
      checkBit("hold_val", o_val, 1'b1);
      checkOutput("hold_dat", o_dat, exp_dat);
      checkBit("hold_err", o_err, exp_err);
    end
    i_rdy = 1'b1;
    @(posedge clk); #1;
    i_rdy = 1'b0;
    checkBit("val_drop", o_val, 1'b0);
    checkBit("err_clear", o_err, 1'b0);
    checkBit("rdy_back", o_rdy, 1'b1);
  endtask

  initial begin
    fe_t a;
    fe_t b;
    bit  seen;
    checks = 0;
    errors = 0;
    i_a    = '0;
    i_b    = '0;
    i_val  = 1'b0;
    i_rdy  = 1'b0;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    $display("[TB] reset state");
    checkBit("rst_rdy", o_rdy, 1'b0);
    checkBit("rst_val", o_val, 1'b0);
    checkBit("rst_err", o_err, 1'b0);
    checkOutput("rst_dat", o_dat, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkBit("rdy_low_after_release", o_rdy, 1'b0);
    @(posedge clk); #1;
    checkBit("rdy_rise", o_rdy, 1'b1);

    $display("[TB] directed operations");
    applyStimulus(fe_t'(1), fe_t'(5), fe_t'(5), 1'b0, 2, 1'b0);
    applyStimulus(fe_t'(2), fe_t'(1),
      256'd10944121435919637611123202872628637544348155578648911831344518947322613104292,
      1'b0, 0, 1'b0);
    applyStimulus(P - fe_t'(1), fe_t'(1), P - fe_t'(1), 1'b0, 0, 1'b0);
    applyStimulus(fe_t'(3), fe_t'(6), fe_t'(2), 1'b0, 0, 1'b0);
    applyStimulus(fe_t'(0), fe_t'(7), fe_t'(0), 1'b1, 1, 1'b0);

    $display("[TB] random operations with backpressure");
    for (int n = 0; n < N_RAND; n++) begin
      a = (rand_fe() % (P - fe_t'(1))) + fe_t'(1);
      b = rand_fe() % P;
      applyStimulus(a, b, fe_inv(a, b), 1'b0, 0, 1'b1);
    end

    $display("[TB] reset during run");
    a = (rand_fe() % (P - fe_t'(1))) + fe_t'(1);
    i_a   = a;
    i_b   = fe_t'(1);
    i_val = 1'b1;
    @(posedge clk); #1;
    i_val = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkBit("midrst_val", o_val, 1'b0);
    checkBit("midrst_err", o_err, 1'b0);
    checkOutput("midrst_dat", o_dat, '0);
    checkBit("midrst_rdy", o_rdy, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (o_val)
        seen = 1'b1;
    end
    checkBit("no_stale_output", seen, 1'b0);
    applyStimulus(fe_t'(5), fe_t'(1), fe_inv(fe_t'(5), fe_t'(1)), 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
